// File: rtl/rbus_pkt_buffer.sv
// Two-class store-and-forward packet buffer for one rbus output channel; whole packets only.
// `define RBUS_PKTBUF_DROP_EN to drop overflowing packets whole instead of forwarding a truncated prefix.
module rbus_pkt_buffer #(
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic        i_sof,
  input  logic [71:0] i_data,
  output logic [1:0]  i_rdy,
  output logic [1:0]  i_rdyE,
  output logic        o_stb,
  output logic        o_sof,
  output logic [71:0] o_data,
  input  logic [1:0]  o_rdy,
  input  logic [1:0]  o_rdyE,
  output logic        ff_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT + 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  // Each entry holds {sof, data}; class selects the upper/lower half.
  logic [72:0]        mem_q [2*DEPTH];
  logic [1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][PW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [1:0][PW-1:0] rd_ptr_q;
`ifdef RBUS_PKTBUF_DROP_EN
  logic [1:0][PW-1:0] start_ptr_q, start_ptr_d;
`endif
  logic               in_pkt_q, in_pkt_d;
  logic               cls_q, cls_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [LW-1:0]      len_q, len_d;
  logic [1:0]         i_rdy_q, i_rdy_d;
  logic [1:0]         i_rdye_q, i_rdye_d;

  logic               mem_we;
  logic [AW:0]        mem_wa;
  logic [72:0]        mem_wd;
  logic               wcls;
  logic               wr_full;
  logic [PW-1:0]      wp;

  state_t             state_q;
  logic               rd_cls_q;
  logic               o_stb_q, o_sof_q;
  logic [71:0]        o_data_q;
  logic [1:0]         avail;
  logic               sel_cls, go, rd_cls;
  logic [72:0]        rd_word;

  logic               unused_ok;
  assign unused_ok = ^o_rdyE;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
`ifdef RBUS_PKTBUF_DROP_EN
    start_ptr_d = start_ptr_q;
`endif
    in_pkt_d  = in_pkt_q;
    cls_d     = cls_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    len_d     = len_q;
    mem_we    = 1'b0;
    mem_wa    = '0;
    mem_wd    = '0;
    wcls      = 1'b0;
    wr_full   = 1'b0;
    wp        = '0;

    // Close the running packet before handling this cycle's word, so a back-to-back
    // packet of the same class starts from the rewound or committed pointer.
    if (in_pkt_q && (!i_stb || i_sof)) begin
      in_pkt_d = 1'b0;
`ifdef RBUS_PKTBUF_DROP_EN
      if (ovf_q) wr_ptr_d[cls_q] = start_ptr_q[cls_q];
      else       cmt_ptr_d[cls_q] = wr_ptr_q[cls_q];
`else
      cmt_ptr_d[cls_q] = wr_ptr_q[cls_q];
`endif
    end

    if (i_stb) begin
      if (i_sof) begin
        in_pkt_d = 1'b1;
        cls_d    = i_data[71];
        ovf_d    = 1'b0;
        len_d    = '0;
`ifdef RBUS_PKTBUF_DROP_EN
        start_ptr_d[i_data[71]] = wr_ptr_d[i_data[71]];
`endif
      end else if (!in_pkt_q) begin
        err_d = 1'b1;
      end

      if (i_sof || in_pkt_q) begin
        wcls    = i_sof ? i_data[71] : cls_q;
        wp      = wr_ptr_d[wcls];
        wr_full = (wp[AW] != rd_ptr_q[wcls][AW]) &&
                  (wp[AW-1:0] == rd_ptr_q[wcls][AW-1:0]);
        // Once a packet overflows, the rest of it is discarded.
        if (!ovf_d) begin
          if (wr_full || (len_d >= LW'(MAX_PKT))) begin
            ovf_d = 1'b1;
            err_d = 1'b1;
          end else begin
            mem_we         = 1'b1;
            mem_wa         = {wcls, wp[AW-1:0]};
            mem_wd         = {i_sof, i_data};
            wr_ptr_d[wcls] = wp + PW'(1);
            len_d          = len_d + LW'(1);
          end
        end
      end
    end

    for (int k = 0; k < 2; k++) begin
      i_rdy_d[k]  = (wr_ptr_q[k] - rd_ptr_q[k]) <= PW'(DEPTH - MAX_PKT);
      i_rdye_d[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
`ifdef RBUS_PKTBUF_DROP_EN
      start_ptr_q <= '0;
`endif
      in_pkt_q  <= 1'b0;
      cls_q     <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      i_rdy_q   <= 2'b11;
      i_rdye_q  <= 2'b11;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
`ifdef RBUS_PKTBUF_DROP_EN
      start_ptr_q <= start_ptr_d;
`endif
      in_pkt_q  <= in_pkt_d;
      cls_q     <= cls_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      len_q     <= len_d;
      i_rdy_q   <= i_rdy_d;
      i_rdye_q  <= i_rdye_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) avail[k] = (cmt_ptr_q[k] != rd_ptr_q[k]);
    sel_cls = avail[1] & o_rdy[1];
    go      = sel_cls | (avail[0] & o_rdy[0]);
    rd_cls  = (state_q == S_IDLE) ? sel_cls : rd_cls_q;
    rd_word = mem_q[{rd_cls, rd_ptr_q[rd_cls][AW-1:0]}];
  end

  // Class 1 has priority; once started, a packet runs to its end regardless of o_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_cls_q <= 1'b0;
      rd_ptr_q <= '0;
      o_stb_q  <= 1'b0;
      o_sof_q  <= 1'b0;
      o_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q           <= S_SEND;
            rd_cls_q          <= sel_cls;
            rd_ptr_q[sel_cls] <= rd_ptr_q[sel_cls] + PW'(1);
            o_stb_q           <= 1'b1;
            o_sof_q           <= rd_word[72];
            o_data_q          <= rd_word[71:0];
          end
        end
        S_SEND: begin
          if (!avail[rd_cls_q] || rd_word[72]) begin
            state_q <= S_IDLE;
            o_stb_q <= 1'b0;
            o_sof_q <= 1'b0;
          end else begin
            rd_ptr_q[rd_cls_q] <= rd_ptr_q[rd_cls_q] + PW'(1);
            o_sof_q            <= rd_word[72];
            o_data_q           <= rd_word[71:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i_rdy  = i_rdy_q;
  assign i_rdyE = i_rdye_q;
  assign o_stb  = o_stb_q;
  assign o_sof  = o_sof_q;
  assign o_data = o_data_q;
  assign ff_err = err_q;

endmodule

// File: tb/tb_rbus_pkt_buffer.sv
// Directed bench for rbus_pkt_buffer: framing, class priority, latency, overflow and reset.
module tb_rbus_pkt_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_stb, i_sof;
  logic [71:0] i_data;
  logic [1:0]  i_rdy, i_rdyE;
  logic        o_stb, o_sof;
  logic [71:0] o_data;
  logic [1:0]  o_rdy, o_rdyE;
  logic        ff_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          gap_err = 0;
  logic        prev_stb = 1'b0;
  logic [72:0] out_q[$];
  logic [72:0] exp_q[$];

  always #5 clk = ~clk;

  rbus_pkt_buffer #(.DEPTH(64), .MAX_PKT(8)) dut (
    .clk(clk), .rst(rst),
    .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
    .i_rdy(i_rdy), .i_rdyE(i_rdyE),
    .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data),
    .o_rdy(o_rdy), .o_rdyE(o_rdyE),
    .ff_err(ff_err)
  );

  // Output monitor: records {sof, data} and flags packets that start without an idle gap.
  always @(negedge clk) begin
    if (o_stb) begin
      out_q.push_back({o_sof, o_data});
      if (o_sof && prev_stb) gap_err++;
    end
    prev_stb = o_stb;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] w(input logic cls, input int v);
    return {cls, 71'(v)};
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic cls, input int base, input int len);
    for (int i = 0; i < len; i++) begin
      i_stb  = 1'b1;
      i_sof  = (i == 0);
      i_data = w(cls, base + i);
      @(posedge clk);
      #1;
    end
    i_stb  = 1'b0;
    i_sof  = 1'b0;
    i_data = '0;
  endtask

  task automatic expect_pkt(input logic cls, input int base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({1'(i == 0), w(cls, base + i)});
  endtask

  task automatic compare_out(input string tag, input int cyc);
    int n;
    ticks(cyc);
    check({tag, "_count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int k;
    rst = 1'b1; i_stb = 1'b0; i_sof = 1'b0; i_data = '0;
    o_rdy = 2'b00; o_rdyE = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ticks(2);

    // 1: reset state
    check("rst_i_rdy",  i_rdy,  2'b11);
    check("rst_i_rdyE", i_rdyE, 2'b11);
    check("rst_o_stb",  o_stb,  1'b0);
    check("rst_o_sof",  o_sof,  1'b0);
    check("rst_o_data", o_data, 72'h0);
    check("rst_ff_err", ff_err, 1'b0);

    // 2: single class-0 packet, latency t+3
    o_rdy = 2'b01;
    send_pkt(1'b0, 'h10, 4);
    check("t2_lat_t1", o_stb, 1'b0);
    ticks(1);
    check("t2_lat_t2", o_stb, 1'b0);
    ticks(1);
    check("t2_lat_t3_stb",  o_stb,  1'b1);
    check("t2_lat_t3_sof",  o_sof,  1'b1);
    check("t2_lat_t3_data", o_data, w(1'b0, 'h10));
    expect_pkt(1'b0, 'h10, 4);
    compare_out("t2", 10);
    check("t2_rdyE_end", i_rdyE, 2'b11);

    // 3: class priority once both become eligible
    o_rdy = 2'b00;
    send_pkt(1'b0, 'h20, 2);
    ticks(1);
    send_pkt(1'b1, 'h30, 3);
    ticks(4);
    check("t3_held", out_q.size(), 0);
    check("t3_rdyE_busy", i_rdyE, 2'b00);
    o_rdy = 2'b11;
    expect_pkt(1'b1, 'h30, 3);
    expect_pkt(1'b0, 'h20, 2);
    compare_out("t3", 20);
    check("t3_gap", gap_err, 0);

    // 4: back-to-back packets split on the second sof
    o_rdy = 2'b01;
    send_pkt(1'b0, 'h40, 3);
    send_pkt(1'b0, 'h50, 2);
    expect_pkt(1'b0, 'h40, 3);
    expect_pkt(1'b0, 'h50, 2);
    compare_out("t4", 20);
    check("t4_gap", gap_err, 0);
    check("t4_no_err", ff_err, 1'b0);

    // 5: i_rdy threshold, then length overflow
    o_rdy = 2'b00;
    for (int p = 0; p < 7; p++) send_pkt(1'b0, 'h100 + p * 16, 8);
    ticks(3);
    check("t5_rdy_at_56", i_rdy[0], 1'b1);
    send_pkt(1'b0, 'h200, 1);
    ticks(3);
    check("t5_rdy_at_57", i_rdy[0], 1'b0);
    check("t5_rdy1_free", i_rdy[1], 1'b1);
    check("t5_no_err_yet", ff_err, 1'b0);
    for (int p = 0; p < 7; p++) expect_pkt(1'b0, 'h100 + p * 16, 8);
    expect_pkt(1'b0, 'h200, 1);
    o_rdy = 2'b01;
    compare_out("t5_drain", 100);
    check("t5_rdy_drained", i_rdy[0], 1'b1);
    send_pkt(1'b0, 'h300, 9);
`ifndef RBUS_PKTBUF_DROP_EN
    expect_pkt(1'b0, 'h300, 8);
`endif
    compare_out("t5_ovf", 30);
    check("t5_err", ff_err, 1'b1);
    check("t5_rdyE", i_rdyE, 2'b11);

    // 6: reset in the middle of SEND
    o_rdy = 2'b10;
    send_pkt(1'b1, 'h600, 8);
    k = 0;
    while (!o_stb && k < 20) begin
      ticks(1);
      k++;
    end
    check("t6_started", o_stb, 1'b1);
    ticks(2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_stb",  o_stb,  1'b0);
    check("t6_rst_rdyE", i_rdyE, 2'b11);
    check("t6_rst_rdy",  i_rdy,  2'b11);
    check("t6_rst_err",  ff_err, 1'b0);
    out_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    o_rdy = 2'b11;
    compare_out("t6_residual", 20);
    check("t6_rdyE_after", i_rdyE, 2'b11);

    // 7: word without sof outside a packet is dropped and flagged
    i_stb = 1'b1; i_sof = 1'b0; i_data = w(1'b0, 'h777);
    ticks(1);
    i_stb = 1'b0; i_data = '0;
    ticks(2);
    check("t7_orphan_err", ff_err, 1'b1);
    compare_out("t7_orphan_drop", 10);
    check("t7_rdyE", i_rdyE, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
